// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the MEM-stage data memory responder.
// Byte strobes are enabled by defining DMEM_BYTE_STROBE_EN.
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int BE_W      = 4;
    localparam int DEPTH_DEF = 1024;
    localparam int WAIT_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word array, synchronous write with per-lane enables,
// registered read. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [BE_W-1:0]   wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: wait-state data memory responder for the MEM stage.
// Optional per-lane store strobes via DMEM_BYTE_STROBE_EN.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [BE_W-1:0]   req_be,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LAST =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t state, state_nx;
    logic [3:0] cnt;
    logic accept, wait_done, fire;

    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              cur_we;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              cur_err;
    logic              err_q;
    logic              ld_q;
    logic [WORD_W-1:0] arr_rdata;

    assign accept    = req_valid & req_ready;
    assign wait_done = (state == WAIT) && (cnt == CNT_LAST);
    assign fire      = (accept && (WAIT_CYCLES == 0)) || wait_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (wait_done) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       cnt <= 4'd0;
        else if (state == WAIT && !wait_done) cnt <= cnt + 4'd1;
        else                              cnt <= 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

`ifdef DMEM_BYTE_STROBE_EN
    logic [BE_W-1:0] be_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      be_q <= '0;
        else if (accept) be_q <= req_be;
    end
    assign cur_be = req_ready ? req_be : be_q;
`else
    assign cur_be = {BE_W{1'b1}};
`endif

    // Zero-wait accesses fire on the accept edge, before the capture regs load
    assign cur_we    = req_ready ? req_we    : we_q;
    assign cur_addr  = req_ready ? req_addr  : addr_q;
    assign cur_wdata = req_ready ? req_wdata : wdata_q;
    assign cur_err   = (|cur_addr[1:0]) | (|cur_addr[WORD_W-1:AW+2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            ld_q  <= 1'b0;
        end else if (fire) begin
            err_q <= cur_err;
            ld_q  <= ~cur_we & ~cur_err;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rd_en (fire & ~cur_we & ~cur_err),
        .wr_en ({BE_W{fire & cur_we & ~cur_err}} & cur_be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign rsp_rdata = (rsp_valid & ld_q) ? arr_rdata : '0;
    assign rsp_err   = rsp_valid & err_q;
    assign stall     = rst_n & req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed vectors for dmem_resp at WAIT_CYCLES=2 and 0.
// Build with DMEM_BYTE_STROBE_EN to cover the strobe variant.
module tb_dmem_resp;

    localparam int WA = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_valid = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [3:0]  a_be = 4'hF;
    logic        a_ready, a_rv, a_err, a_stall;
    logic [31:0] a_rdata;

    logic        b_valid = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [3:0]  b_be = 4'hF;
    logic        b_ready, b_rv, b_err, b_stall;
    logic [31:0] b_rdata;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(WA)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_valid),
        .req_we    (a_we),
        .req_addr  (a_addr),
        .req_wdata (a_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be    (a_be),
`endif
        .req_ready (a_ready),
        .rsp_valid (a_rv),
        .rsp_rdata (a_rdata),
        .rsp_err   (a_err),
        .stall     (a_stall)
    );

    dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_valid),
        .req_we    (b_we),
        .req_addr  (b_addr),
        .req_wdata (b_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be    (b_be),
`endif
        .req_ready (b_ready),
        .rsp_valid (b_rv),
        .rsp_rdata (b_rdata),
        .rsp_err   (b_err),
        .stall     (b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xact_a(input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rd,
                          input logic exp_er);
        int lat, stl;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        a_valid = 1'b1; a_we = we; a_addr = addr;
        a_wdata = wdata; a_be = be;
        lat = -1; stl = 0; rd = '0; er = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (a_rv) begin
                lat = n; rd = a_rdata; er = a_err;
                break;
            end
            if (a_stall) stl++;
        end
        a_valid = 1'b0;
        chk({tag, ".lat"}, lat, WA + 1);
        chk({tag, ".stall"}, stl, WA + 1);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_er});
        @(negedge clk);
        #1;
        chk({tag, ".pulse"}, {31'd0, a_rv}, 32'd0);
        chk({tag, ".idle_rd"}, a_rdata, 32'd0);
    endtask

    // Called at a sample point; drives the next request immediately
    task automatic xact_b(input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_er);
        int acc, lat;
        logic rdy;
        logic [31:0] rd;
        logic er;
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        b_be = 4'hF;
        acc = -1; lat = -1; rdy = 1'b1; rd = '0; er = 1'b0;
        #1;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) begin
                @(negedge clk);
                #1;
            end
            if (acc >= 0 && n > acc && b_rv) begin
                lat = n - acc; rdy = b_ready; rd = b_rdata; er = b_err;
                break;
            end
            if (acc < 0 && b_ready) acc = n;
        end
        chk({tag, ".lat"}, lat, 1);
        chk({tag, ".ready_in_resp"}, {31'd0, rdy}, 32'd0);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_er});
    endtask

    initial begin
        logic seen;
        a_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.ready", {31'd0, a_ready}, 1);
        chk("rst.rv", {31'd0, a_rv}, 0);
        chk("rst.rdata", a_rdata, 0);
        chk("rst.err", {31'd0, a_err}, 0);
        chk("rst.stall", {31'd0, a_stall}, 0);
        a_valid = 1'b0;
        rst_n = 1'b1;

        xact_a("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xact_a("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        xact_a("ld12", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        xact_a("ld10b", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        xact_a("st11", 1'b1, 32'h11, 32'h12345678, 4'hF, 32'h0, 1'b1);
        xact_a("ld10c", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        xact_a("st0", 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
        xact_a("stFFC", 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        xact_a("st1000", 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b1);
        xact_a("ld0", 1'b0, 32'h0, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0);
        xact_a("ldFFC", 1'b0, 32'hFFC, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
        xact_a("ld1000", 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1);

        xact_a("be.init", 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
        xact_a("be.st", 1'b1, 32'h30, 32'h11223344, 4'b0101, 32'h0, 1'b0);
`ifdef DMEM_BYTE_STROBE_EN
        xact_a("be.ld", 1'b0, 32'h30, 32'h0, 4'hF, 32'hFF22FF44, 1'b0);
        xact_a("be.zero", 1'b1, 32'h30, 32'hAAAAAAAA, 4'h0, 32'h0, 1'b0);
        xact_a("be.ld2", 1'b0, 32'h30, 32'h0, 4'hF, 32'hFF22FF44, 1'b0);
`else
        xact_a("be.ld", 1'b0, 32'h30, 32'h0, 4'hF, 32'h11223344, 1'b0);
`endif

        xact_a("st20", 1'b1, 32'h20, 32'h00000077, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20;
        a_wdata = 32'h5; a_be = 4'hF;
        @(negedge clk);
        #1;
        chk("abort.in_wait", {31'd0, a_ready}, 0);
        rst_n = 1'b0;
        #1;
        chk("abort.ready", {31'd0, a_ready}, 1);
        chk("abort.stall", {31'd0, a_stall}, 0);
        chk("abort.rv", {31'd0, a_rv}, 0);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (a_rv) seen = 1'b1;
        end
        chk("abort.no_rsp", {31'd0, seen}, 0);
        chk("abort.ready_after", {31'd0, a_ready}, 1);
        xact_a("abort.ld20", 1'b0, 32'h20, 32'h0, 4'hF, 32'h00000077, 1'b0);

        @(negedge clk);
        #1;
        xact_b("b.st40", 1'b1, 32'h40, 32'hCAFE0001, 32'h0, 1'b0);
        xact_b("b.ld40", 1'b0, 32'h40, 32'h0, 32'hCAFE0001, 1'b0);
        xact_b("b.st41", 1'b1, 32'h41, 32'h99999999, 32'h0, 1'b1);
        xact_b("b.st44", 1'b1, 32'h44, 32'h0000BEEF, 32'h0, 1'b0);
        xact_b("b.ld40b", 1'b0, 32'h40, 32'h0, 32'hCAFE0001, 1'b0);
        xact_b("b.ld44", 1'b0, 32'h44, 32'h0, 32'h0000BEEF, 1'b0);
        b_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("b.pulse", {31'd0, b_rv}, 0);
        chk("b.idle_rd", b_rdata, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
